shiftreg_seq_ctrl: RTL and testbench

- Sequencer that drives the serial input of the team's fixed-depth DFF shift chain (DEPTH stages, shared clock).
- Accepts a parallel word over a valid/ready handshake and presents it LSB-first on the chain's serial input, one bit per clock.
- Pads with zeros for DEPTH cycles so the last data bit reaches the chain output, then pulses done.
- Sits between a host/testbench word source and the shift chain; the chain itself is unchanged.

---
 rtl/shiftreg_seq_ctrl_if.sv | 26 ++
 rtl/shiftreg_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_shiftreg_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_seq_ctrl_if.sv
// Word-side handshake bundle for the shift-chain sequencer.
// The host (master) offers a parallel word plus a length; the sequencer
// (slave) raises in_ready while it can take one.
interface shiftreg_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int LW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;

  modport master (
    output in_valid,
    output in_data,
    output in_len,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_len,
    output in_ready
  );
endinterface

// File: rtl/shiftreg_seq_ctrl.sv
// Serializer that feeds a DEPTH-stage DFF shift chain.
// A word taken over the valid/ready handshake is presented LSB-first on
// sdo_o, one bit per clock, followed by zero padding until the last data bit
// has travelled to the chain output; done_o pulses in exactly that cycle.
// Every output comes straight from a flop, so nothing on the serial side
// depends combinationally on the host inputs.
module shiftreg_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  shiftreg_seq_ctrl_if.slave  in_if,
  output logic                sdo_o,
  output logic                sdo_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [LW-1:0]       bit_cnt_o
);

  // The pad counter only has to reach DEPTH-1; keep it at least one bit wide
  // so a DEPTH=1 build still elaborates (it is simply never advanced there).
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PAD_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PAD_ONE  = PW'(1);
  localparam logic [LW-1:0] WIDTH_L  = LW'(WIDTH);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]    pad_q, pad_d;
  logic             sdo_q, sdo_d;
  logic             sdo_valid_q, sdo_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer;

  // A requested length of zero, or one longer than the word, means "whole word".
  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
    if ((len == '0) || (len > WIDTH_L)) begin
      return WIDTH_L;
    end
    return len;
  endfunction

  // in_ready_q is only ever high in IDLE, so this is the handshake edge.
  assign xfer = in_if.in_valid && in_ready_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    pad_d       = pad_q;
    sdo_d       = 1'b0;
    sdo_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          // Bit 0 goes out on the transfer edge itself; the buffer keeps
          // the remaining bits already shifted down by one.
          state_d     = S_SHIFT;
          shift_d     = {1'b0, in_if.in_data[WIDTH-1:1]};
          len_d       = eff_len(in_if.in_len);
          sdo_d       = in_if.in_data[0];
          sdo_valid_d = 1'b1;
          bit_cnt_d   = CNT_ONE;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == len_q) begin
          // All data bits are out; bit_cnt holds at L from here on.
          if (DEPTH == 1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FLUSH;
            pad_d   = PAD_ONE;
          end
        end else begin
          sdo_d       = shift_q[0];
          sdo_valid_d = 1'b1;
          shift_d     = {1'b0, shift_q[WIDTH-1:1]};
          bit_cnt_d   = bit_cnt_q + CNT_ONE;
        end
      end

      S_FLUSH: begin
        // Zeros keep pushing the last data bit down the chain.
        if (pad_q == PAD_LAST) begin
          state_d = S_DONE;
        end else begin
          pad_d = pad_q + PAD_ONE;
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        pad_d     = '0;
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        pad_d     = '0;
      end
    endcase

    // Status flags are decoded from the next state so they can be registered.
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers; reset drops any partial word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      pad_q       <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      pad_q       <= pad_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign sdo_o          = sdo_q;
  assign sdo_valid_o    = sdo_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign bit_cnt_o      = bit_cnt_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Directed bench for shiftreg_seq_ctrl: a DEPTH=4 instance with a model
// shift chain on its sdo, plus a DEPTH=1 instance for the no-flush case.
module tb_shiftreg_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int LW    = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  shiftreg_seq_ctrl_if #(.WIDTH(WIDTH), .LW(LW)) bus0 ();
  shiftreg_seq_ctrl_if #(.WIDTH(WIDTH), .LW(LW)) bus1 ();

  logic          sdo0, sdo_valid0, busy0, done0;
  logic [LW-1:0] bit_cnt0;
  logic          sdo1, sdo_valid1, busy1, done1;
  logic [LW-1:0] bit_cnt1;

  shiftreg_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus0),
    .sdo_o       (sdo0),
    .sdo_valid_o (sdo_valid0),
    .busy_o      (busy0),
    .done_o      (done0),
    .bit_cnt_o   (bit_cnt0)
  );

  shiftreg_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(1), .LW(LW)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus1),
    .sdo_o       (sdo1),
    .sdo_valid_o (sdo_valid1),
    .busy_o      (busy1),
    .done_o      (done1),
    .bit_cnt_o   (bit_cnt1)
  );

  // Model of the driven DFF chains (no reset, like the real chain).
  logic [DEPTH-1:0] chain0 = '0;
  logic             chain1 = 1'b0;
  always @(posedge clk) begin
    chain0 <= {chain0[DEPTH-2:0], sdo0};
    chain1 <= sdo1;
  end
  wire chain0_out = chain0[DEPTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    int         exp_len;
    logic [7:0] exp_bits;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  // Sends one word on DUT0 and checks it cycle by cycle, c counting from the
  // transfer edge. With hold=1, in_valid stays high with 8'h0F queued.
  task automatic run_word(input string nm, input logic [7:0] data, input logic [3:0] len,
                          input int exp_len, input logic [7:0] exp_bits, input int exp_done,
                          input bit hold);
    chk({nm, " ready_before"}, 32'(bus0.in_ready), 32'd1);
    bus0.in_valid = 1'b1;
    bus0.in_data  = data;
    bus0.in_len   = len;
    tick();
    if (hold) begin
      bus0.in_data = 8'h0F;
      bus0.in_len  = 4'd0;
    end else begin
      bus0.in_valid = 1'b0;
    end
    for (int c = 0; c <= exp_len + DEPTH; c++) begin
      chk($sformatf("%s done c%0d", nm, c), 32'(done0), 32'(c == exp_done));
      if (c < exp_len) begin
        chk($sformatf("%s sdo c%0d", nm, c), 32'(sdo0), 32'(exp_bits[c]));
        chk($sformatf("%s sdo_valid c%0d", nm, c), 32'(sdo_valid0), 32'd1);
        chk($sformatf("%s bit_cnt c%0d", nm, c), 32'(bit_cnt0), 32'(c + 1));
      end else if (c < exp_len + DEPTH) begin
        chk($sformatf("%s pad sdo c%0d", nm, c), {31'd0, sdo0, sdo_valid0}, 32'd0);
        chk($sformatf("%s bit_cnt hold c%0d", nm, c), 32'(bit_cnt0), 32'(exp_len));
      end
      if (c < exp_len + DEPTH) begin
        chk($sformatf("%s busy c%0d", nm, c), {30'd0, busy0, bus0.in_ready}, 32'b10);
      end else begin
        chk($sformatf("%s idle", nm), {30'd0, busy0, bus0.in_ready}, 32'b01);
        chk($sformatf("%s idle bit_cnt", nm), 32'(bit_cnt0), 32'd0);
      end
      if (c >= DEPTH && c < exp_len + DEPTH) begin
        chk($sformatf("%s chain c%0d", nm, c), 32'(chain0_out), 32'(exp_bits[c - DEPTH]));
      end
      if (c < exp_len + DEPTH) tick();
    end
  endtask

  initial begin
    int pulses;
    vecs[0] = '{8'hB5, 4'd0,  8, 8'hB5, 11};
    vecs[1] = '{8'hFF, 4'd3,  3, 8'h07,  6};
    vecs[2] = '{8'hFF, 4'd9,  8, 8'hFF, 11};
    vecs[3] = '{8'h5A, 4'd1,  1, 8'h00,  4};
    vecs[4] = '{8'h81, 4'd15, 8, 8'h81, 11};
    vecs[5] = '{8'h3C, 4'd8,  8, 8'h3C, 11};
    vecs[6] = '{8'hC6, 4'd6,  6, 8'h06,  9};

    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_len = '0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_len = '0;
    tick();
    tick();
    chk("reset outs", {26'd0, sdo0, sdo_valid0, busy0, done0, bus0.in_ready, 1'b0}, 32'b000010);
    chk("reset bit_cnt", 32'(bit_cnt0), 32'd0);
    rst = 1'b0;
    tick();

    // Async reset mid-cycle, no clock edge in between.
    bus0.in_valid = 1'b1; bus0.in_data = 8'hFF; bus0.in_len = 4'd0;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    chk("pre-async busy", 32'(busy0), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async outs", {27'd0, sdo0, sdo_valid0, busy0, done0, bus0.in_ready}, 32'b00001);
    chk("async bit_cnt", 32'(bit_cnt0), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table of words.
    for (int i = 0; i < 7; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].len,
               vecs[i].exp_len, vecs[i].exp_bits, vecs[i].exp_done, 1'b0);
      tick();
    end

    // Busy hold-off: 8'h0F offered all through the 8'hB5 word.
    run_word("hold_b5", 8'hB5, 4'd0, 8, 8'hB5, 11, 1'b1);
    run_word("hold_0f", 8'h0F, 4'd0, 8, 8'h0F, 11, 1'b0);
    tick();

    // Reset after five bits of 8'hB5: no done, then 8'h01 from bit 0.
    bus0.in_valid = 1'b1; bus0.in_data = 8'hB5; bus0.in_len = 4'd0;
    tick();
    bus0.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst bit_cnt", 32'(bit_cnt0), 32'd5);
    #3 rst = 1'b1;
    #1;
    chk("midrst outs", {27'd0, sdo0, sdo_valid0, busy0, done0, bus0.in_ready}, 32'b00001);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done0 || busy0) pulses++;
    end
    chk("midrst no done", 32'(pulses), 32'd0);
    run_word("after_rst", 8'h01, 4'd0, 8, 8'h01, 11, 1'b0);
    tick();

    // Reset and in_valid together: no transfer.
    rst = 1'b1;
    bus0.in_valid = 1'b1; bus0.in_data = 8'hAA;
    tick();
    chk("rst wins", {29'd0, busy0, sdo_valid0, bus0.in_ready}, 32'b001);
    rst = 1'b0;
    bus0.in_valid = 1'b0;
    tick();
    chk("rst wins after", 32'(busy0), 32'd0);

    // DEPTH=1 instance: two bits, done right after, no flush.
    bus1.in_valid = 1'b1; bus1.in_data = 8'h02; bus1.in_len = 4'd2;
    tick();
    bus1.in_valid = 1'b0;
    chk("d1 c0", {28'd0, sdo1, sdo_valid1, done1, busy1}, 32'b0101);
    tick();
    chk("d1 c1", {28'd0, sdo1, sdo_valid1, done1, busy1}, 32'b1101);
    chk("d1 c1 chain", 32'(chain1), 32'd0);
    chk("d1 c1 bit_cnt", 32'(bit_cnt1), 32'd2);
    tick();
    chk("d1 c2 done", {28'd0, sdo1, sdo_valid1, done1, busy1}, 32'b0011);
    chk("d1 c2 chain", 32'(chain1), 32'd1);
    tick();
    chk("d1 c3 idle", {29'd0, done1, busy1, bus1.in_ready}, 32'b001);
    chk("d1 c3 bit_cnt", 32'(bit_cnt1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
